matrix_stream_source: RTL

Producer for the fixed-point dot-product path: walks matrix A (ROWS×LENGTH) and matrix B (LENGTH×COLS), held in external synchronous RAMs, and emits the paired element streams that stream_multiply_accumulate consumes. It emits one dot product of LENGTH pairs per output element C[i][j], in row-major (i,j) order. It sits between the operand RAMs and the MAC chain, and it drives the MAC's `in_valid`, `a` and `b` directly.

---
 rtl/matrix_stream_pkg.sv | 28 ++
 rtl/matrix_index_counter.sv | 97 +++++++++
 rtl/matrix_stream_source.sv | 106 ++++++++++
 3 files changed

// File: rtl/matrix_stream_pkg.sv
// matrix_stream_pkg: shared FSM state type and address-width helpers
// for the matrix stream source. Optional GAP state exists only when
// MATRIX_STREAM_GAP_EN is defined.
package matrix_stream_pkg;

    // Counter/address width, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int a_addr_w(input int rows, input int length);
        return cnt_w(rows * length);
    endfunction

    function automatic int b_addr_w(input int length, input int cols);
        return cnt_w(length * cols);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
`ifdef MATRIX_STREAM_GAP_EN
        S_GAP   = 2'd2,
`endif
        S_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/matrix_index_counter.sv
// matrix_index_counter: nested i/j/k counters (k innermost) that keep the
// A and B RAM addresses up to date incrementally, without multipliers.
// Ports: clk, rst (sync, active-high), step (advance one index),
//        a_addr/b_addr (current addresses), k_last (k==LENGTH-1),
//        last (final index of the pass).
module matrix_index_counter
    import matrix_stream_pkg::*;
#(
    parameter int LENGTH = 10,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    localparam int AW = a_addr_w(ROWS, LENGTH),
    localparam int BW = b_addr_w(LENGTH, COLS),
    localparam int IW = cnt_w(ROWS),
    localparam int JW = cnt_w(COLS),
    localparam int KW = cnt_w(LENGTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [AW-1:0] a_addr,
    output logic [BW-1:0] b_addr,
    output logic          k_last,
    output logic          last
);

    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic [KW-1:0] k_q, k_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] row_q, row_d;
    logic [BW-1:0] b_q, b_d;
    logic          j_end;
    logic          i_end;

    assign k_last = (k_q == KW'(LENGTH - 1));
    assign j_end  = (j_q == JW'(COLS - 1));
    assign i_end  = (i_q == IW'(ROWS - 1));
    assign last   = k_last & j_end & i_end;
    assign a_addr = a_q;
    assign b_addr = b_q;

    always_comb begin
        i_d   = i_q;
        j_d   = j_q;
        k_d   = k_q;
        a_d   = a_q;
        row_d = row_q;
        b_d   = b_q;
        if (step) begin
            if (!k_last) begin
                k_d = k_q + 1'b1;
                a_d = a_q + 1'b1;
                b_d = b_q + BW'(COLS);
            end else if (!j_end) begin
                // Next column: A rewinds to the row start, B to row 0 of col j+1.
                k_d = '0;
                j_d = j_q + 1'b1;
                a_d = row_q;
                b_d = BW'(j_q) + 1'b1;
            end else if (!i_end) begin
                k_d   = '0;
                j_d   = '0;
                i_d   = i_q + 1'b1;
                row_d = row_q + AW'(LENGTH);
                a_d   = row_q + AW'(LENGTH);
                b_d   = '0;
            end else begin
                k_d   = '0;
                j_d   = '0;
                i_d   = '0;
                row_d = '0;
                a_d   = '0;
                b_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            a_q   <= '0;
            row_q <= '0;
            b_q   <= '0;
        end else begin
            i_q   <= i_d;
            j_q   <= j_d;
            k_q   <= k_d;
            a_q   <= a_d;
            row_q <= row_d;
            b_q   <= b_d;
        end
    end

endmodule

// File: rtl/matrix_stream_source.sv
// matrix_stream_source: walks A (ROWS x LENGTH) and B (LENGTH x COLS) in
// external sync RAMs and streams A[i][k]/B[k][j] pairs, k innermost, one
// dot product per C[i][j]. MATRIX_STREAM_GAP_EN inserts one idle cycle
// between dot products.
// Ports: clk, rst (sync, active-high), start, busy, done (pulse),
//        a_addr/a_rdata, b_addr/b_rdata (RAM, 1-cycle read latency),
//        out_valid, a, b, out_last (k==LENGTH-1 pair).
module matrix_stream_source
    import matrix_stream_pkg::*;
#(
    parameter int BITS   = 16,
    parameter int LENGTH = 10,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    localparam int AW = a_addr_w(ROWS, LENGTH),
    localparam int BW = b_addr_w(LENGTH, COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   a_addr,
    input  logic [BITS-1:0] a_rdata,
    output logic [BW-1:0]   b_addr,
    input  logic [BITS-1:0] b_rdata,
    output logic            out_valid,
    output logic [BITS-1:0] a,
    output logic [BITS-1:0] b,
    output logic            out_last
);

    state_t state_q;
    logic   busy_q;
    logic   done_q;
    logic   valid_q;
    logic   last_q;
    logic   issue;
    logic   k_last;
    logic   last;

    assign issue = (state_q == S_RUN);

    matrix_index_counter #(
        .LENGTH (LENGTH),
        .ROWS   (ROWS),
        .COLS   (COLS)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .step   (issue),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .k_last (k_last),
        .last   (last)
    );

    // Issue flags are delayed one stage to line up with RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            valid_q <= issue;
            last_q  <= issue & k_last;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (last) begin
                        state_q <= S_DRAIN;
`ifdef MATRIX_STREAM_GAP_EN
                    end else if (k_last) begin
                        state_q <= S_GAP;
`endif
                    end
                end
`ifdef MATRIX_STREAM_GAP_EN
                S_GAP: state_q <= S_RUN;
`endif
                S_DRAIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign a         = a_rdata;
    assign b         = b_rdata;

endmodule
